// File: rtl/seg_display_scan.sv
// Six-digit multiplexed seven-segment driver for the alarm-clock core.
// Latches one time snapshot per scan frame and flashes the display while the alarm is active.
module seg_display_scan #(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] H_out1,
   input  logic [3:0] H_out0,
   input  logic [3:0] M_out1,
   input  logic [3:0] M_out0,
   input  logic [3:0] S_out1,
   input  logic [3:0] S_out0,
   input  logic       Alarm,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

   typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5} digit_t;

   logic [PW-1:0] pcnt_reg, pcnt_next;
   digit_t        d_reg, d_next;
   logic [FW-1:0] fcnt_reg, fcnt_next;
   logic          phase_reg, phase_next;
   logic          alarm_reg, alarm_next;
   logic [3:0]    snap_reg  [6];
   logic [3:0]    snap_next [6];
   logic [3:0]    digit_in  [6];
   logic [5:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;
   logic [3:0]    cur_val;
   logic          tick;
   logic          wrap;

   assign tick = (pcnt_reg == PCNT_MAX);
   assign wrap = tick && (d_reg == D5);

   assign digit_in[0] = S_out0;
   assign digit_in[1] = S_out1;
   assign digit_in[2] = M_out0;
   assign digit_in[3] = M_out1;
   assign digit_in[4] = H_out0;
   assign digit_in[5] = {2'b00, H_out1};

   // Rendering looks only at the snapshot, so a frame never mixes two times.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_snap
         assign snap_next[gi] = wrap ? digit_in[gi] : snap_reg[gi];
      end
   endgenerate

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   always_comb begin
      pcnt_next  = tick ? '0 : pcnt_reg + 1'b1;
      d_next     = d_reg;
      fcnt_next  = fcnt_reg;
      phase_next = phase_reg;
      alarm_next = alarm_reg;

      if (tick) begin
         case (d_reg)
            D0:      d_next = D1;
            D1:      d_next = D2;
            D2:      d_next = D3;
            D3:      d_next = D4;
            D4:      d_next = D5;
            default: d_next = D0;
         endcase
      end

      // The flash counter only runs across consecutive alarm frames; the
      // first alarm frame after a quiet one always starts in the lit phase.
      if (wrap) begin
         alarm_next = Alarm;
         if (Alarm && alarm_reg) begin
            if (fcnt_reg == FCNT_MAX) begin
               fcnt_next  = '0;
               phase_next = ~phase_reg;
            end else begin
               fcnt_next = fcnt_reg + 1'b1;
            end
         end else begin
            fcnt_next  = '0;
            phase_next = 1'b0;
         end
      end

      cur_val  = snap_next[d_next];
      an_next  = ~(6'b000001 << d_next);
      seg_next = seg_decode(cur_val);
      if ((d_next == D5) && (snap_next[5] == 4'd0)) begin
         seg_next = 7'b1111111;
      end
      dp_next = !(((d_next == D2) || (d_next == D4)) && !snap_next[0][0]);

      if (alarm_next && phase_next) begin
         an_next  = 6'b111111;
         seg_next = 7'b1111111;
         dp_next  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pcnt_reg    <= PCNT_MAX;
         d_reg       <= D5;
         fcnt_reg    <= '0;
         phase_reg   <= 1'b0;
         alarm_reg   <= 1'b0;
         for (int i = 0; i < 6; i++) snap_reg[i] <= 4'd0;
         an          <= 6'b111111;
         seg         <= 7'b1111111;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         pcnt_reg    <= pcnt_next;
         d_reg       <= d_next;
         fcnt_reg    <= fcnt_next;
         phase_reg   <= phase_next;
         alarm_reg   <= alarm_next;
         for (int i = 0; i < 6; i++) snap_reg[i] <= snap_next[i];
         an          <= an_next;
         seg         <= seg_next;
         dp          <= dp_next;
         frame_start <= wrap;
      end
   end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a frame-level reference model queues the
// expected display per clock edge, a monitor pops and compares after each edge.
module tb_seg_display_scan;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FL = 6 * SD;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] h1;
   logic [3:0] h0, m1, m0, s1, s0;
   logic       alarm;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   always #5 clk = ~clk;

   seg_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset),
      .H_out1(h1), .H_out0(h0), .M_out1(m1), .M_out0(m0), .S_out1(s1), .S_out0(s0),
      .Alarm(alarm), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
   );

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         passes = 0;
   int         cyc = 0;

   // Reference model: position in the frame follows from elapsed cycles.
   int         t = 0;
   logic [3:0] m_snap [6];
   logic       m_alarm = 1'b0;
   int         m_k = 0;
   logic [6:0] dec_tab [16];

   initial begin
      dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001; dec_tab[2] = 7'b0100100;
      dec_tab[3] = 7'b0110000; dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
      dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000; dec_tab[8] = 7'b0000000;
      dec_tab[9] = 7'b0010000;
      for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;
      for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
   end

   task automatic model_edge();
      exp_t e;
      int   pos;
      int   dig;
      e = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      if (!reset) begin
         t       = 0;
         m_alarm = 1'b0;
         m_k     = 0;
         for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
      end else begin
         pos  = t % FL;
         dig  = pos / SD;
         e.fs = (pos == 0);
         if (pos == 0) begin
            m_k       = (alarm && m_alarm) ? m_k + 1 : 0;
            m_alarm   = alarm;
            m_snap[0] = s0; m_snap[1] = s1; m_snap[2] = m0;
            m_snap[3] = m1; m_snap[4] = h0; m_snap[5] = {2'b00, h1};
         end
         if (!(m_alarm && ((m_k / BF) % 2 == 1))) begin
            e.an  = ~(6'(1) << dig);
            e.seg = (dig == 5 && m_snap[5] == 4'd0) ? 7'h7F : dec_tab[m_snap[dig]];
            e.dp  = !((dig == 2 || dig == 4) && !m_snap[0][0]);
         end
         t++;
      end
      exp_q.push_back(e);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_time(input int hh, input int mm, input int ss);
      h1 = 2'(hh / 10); h0 = 4'(hh % 10);
      m1 = 4'(mm / 10); m0 = 4'(mm % 10);
      s1 = 4'(ss / 10); s0 = 4'(ss % 10);
   endtask

   task automatic run_to_digit(input int dig);
      while (((t % FL) / SD) != dig || (t % SD) != 0) step();
   endtask

   // Monitor: one comparison per edge against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
               $display("FAIL display cyc=%0d got an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
                        cyc, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end else begin
               passes++;
               if (e.fs)
                  $display("frame cyc=%0d an=%b seg=%b dp=%b", cyc, an, seg, dp);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      alarm = 1'($urandom_range(0, 1));
      set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      repeat (3) step();

      set_time(12, 34, 56);
      alarm = 1'b0;
      reset = 1'b1;
      repeat (2 * FL) step();

      set_time(9, 5, 7);
      repeat (2 * FL) step();

      set_time(12, 34, 56);
      run_to_digit(1);
      m0 = 4'd7;
      repeat (2 * FL) step();

      alarm = 1'b1;
      repeat (6 * FL) step();
      repeat (FL / 2) step();
      alarm = 1'b0;
      repeat (2 * FL) step();

      m1 = 4'd12;
      repeat (FL) step();
      run_to_digit(3);
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      repeat (2 * FL) step();

      repeat (1500) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 5))
               0: s0 = 4'($urandom_range(0, 15));
               1: s1 = 4'($urandom_range(0, 15));
               2: m0 = 4'($urandom_range(0, 15));
               3: m1 = 4'($urandom_range(0, 15));
               4: h0 = 4'($urandom_range(0, 15));
               default: h1 = 2'($urandom_range(0, 3));
            endcase
         end
         if ($urandom_range(0, 149) == 0) alarm = ~alarm;
         reset = ($urandom_range(0, 299) != 0);
         step();
      end

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
      else
         passes++;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Multiplexed six-digit seven-segment display driver sitting directly downstream of the `aclock` alarm-clock core. Consumes its BCD time outputs (HH:MM:SS) and `Alarm` flag and drives common-anode digit enables and segment lines, one digit at a time. Latches a coherent snapshot of the time once per scan frame so no frame mixes two different times. Flashes the whole display while the alarm is active.

## Interface

- `SCAN_DIV`, default 4: clk cycles each digit stays lit (≥1).
- `BLINK_FRAMES`, default 8: frames per alarm-flash half-period (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `H_out1`  in  2  hours tens (BCD).
- `H_out0`  in  4  hours units.
- `M_out1`  in  4  minutes tens.
- `M_out0`  in  4  minutes units.
- `S_out1`  in  4  seconds tens.
- `S_out0`  in  4  seconds units.
- `Alarm`  in  1  alarm active from the clock core.
- `an`  out  6  digit enables, active-low; bit k = digit index k.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_start`  out  1  one-cycle pulse on each snapshot load.

## Operation

- Prescaler `pcnt` counts 0..SCAN_DIV-1. `tick` = (`pcnt` == SCAN_DIV-1).
- Digit index `d` advances on `tick` and wraps 5→0. Mapping: d0=S_out0, d1=S_out1, d2=M_out0, d3=M_out1, d4=H_out0, d5=H_out1.
- Snapshot: on a `tick` where `d` wraps 5→0, all six digits and `Alarm` are loaded into snapshot registers and `frame_start`=1 for that cycle. Rendering uses only the snapshot. Input changes mid-frame are ignored until the next frame.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - values 10–15 render as dash 0111111.
- Leading-zero blank: at d5, if snapshot H tens = 0, then `seg`=1111111. `an` is still asserted.
- `dp`=0 at d2 and d4 only when snapshot S_out0[0]=0, giving a 1 Hz separator blink. Otherwise `dp`=1.
- Alarm flash: frame counter `fcnt` counts 0..BLINK_FRAMES-1 per frame_start. `phase` toggles at each wrap.
  - If snapshot Alarm=1 and `phase`=1: `an`=111111, `seg`=1111111, `dp`=1.
  - If snapshot Alarm=0: `fcnt` and `phase` are held at 0.
- States: scan (d 0..5) × flash phase (on/blank). No other modes.

## Timing

- All outputs are registered. They are computed from next-state values, so `an`/`seg`/`dp` change on the same edge as `d` and the snapshot.
- Reset (reset=0 at an edge) values: `pcnt`=SCAN_DIV-1, `d`=5, snapshot=0, `fcnt`=0, `phase`=0, `an`=111111, `seg`=1111111, `dp`=1, `frame_start`=0.
- First cycle with reset=1 is a wrap tick:
  - `frame_start`=1 in that cycle.
  - Digit 0 of the new snapshot is displayed from the following edge.
- Frame length = 6·SCAN_DIV cycles. `frame_start` period equals frame length exactly.
- Input-to-display latency: inputs sampled at the wrap-tick edge. Worst case one full frame plus one cycle.
- Reset asserted mid-frame: reset values apply at the next edge, with no partial-frame completion.
- Alarm deasserting mid-frame: flash state persists until the next snapshot. The next frame displays normally with `phase`=0.
- SCAN_DIV=1: `tick` every cycle, `d` advances every cycle.

## Test plan

- Hold reset=0 for 3 cycles with any inputs -> `an`=111111, `seg`=1111111, `dp`=1, `frame_start`=0 throughout.
- SCAN_DIV=4, time 12:34:56, Alarm=0, release reset ->
  - `frame_start` high in the 1st cycle after release, then every 24 cycles.
  - Each digit held 4 cycles: an=111110/seg=0000010, an=111101/0010010, an=111011/0011001, an=110111/0110000, an=101111/0100100, an=011111/1111001.
  - `dp`=0 during an=111011 and an=101111.
- Time 09:05:07 -> at an=011111, `seg`=1111111 (blanked). `dp`=1 at all digits (S_out0 odd).
- Change M_out0 4→7 while d=1 -> d2 shows 0011001 in the current frame and 1111000 in the next frame.
- BLINK_FRAMES=2, Alarm=1 -> frames alternate 2 normal / 2 blank (an=111111). Drop Alarm -> the frame after the next snapshot is normal.
- M_out1=12 -> d3 `seg`=0111111. Pull reset=0 mid-frame at d=3 -> reset values on the next edge; restart shows `frame_start` on the 1st cycle after release.
